// File: rtl/pipe_fd_regs.sv
// Fetch/decode/execute pipeline state: PC, IF/ID and ID/EX registers with
// valid tracking, saturating stall/flush event counters and a sticky protocol-error flag.
module pipe_fd_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CTRL_W   = 12,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushE,
    input  logic              pcsrcD,
    input  logic              jumpD,
    input  logic [31:0]       pcbranchD,
    input  logic [31:0]       pcjumpD,
    input  logic [31:0]       instrF,
    output logic [31:0]       pcF,
    output logic [31:0]       instrD,
    output logic [31:0]       pcplus4D,
    output logic              validD,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [31:0]       rd1D,
    input  logic [31:0]       rd2D,
    input  logic [31:0]       signimmD,
    input  logic [4:0]        rsD,
    input  logic [4:0]        rtD,
    input  logic [4:0]        rdD,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [31:0]       rd1E,
    output logic [31:0]       rd2E,
    output logic [31:0]       signimmE,
    output logic [4:0]        rsE,
    output logic [4:0]        rtE,
    output logic [4:0]        rdE,
    output logic [31:0]       pcplus4E,
    output logic              validE,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              proto_err
);

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pcPlus4;
    logic        stallSat;
    logic        flushSat;
    logic        protoViolation;

    // Decode-stage redirect only counts when IF/ID holds a real instruction; jump wins.
    always_comb begin
        redirect       = validD & (jumpD | pcsrcD);
        target         = jumpD ? pcjumpD : pcbranchD;
        pcPlus4        = pcF + 32'd4;
        stallSat       = &stall_cnt;
        flushSat       = &flush_cnt;
        protoViolation = (stallF != stallD) | (stallD & ~flushE & validD);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcF <= RESET_PC;
        end else if (!stallF) begin
            pcF <= redirect ? target : pcPlus4;
        end
    end

    // IF/ID: squash the fall-through slot on a redirect.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            instrD   <= 32'd0;
            pcplus4D <= 32'd0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            pcplus4D <= pcPlus4;
            if (redirect) begin
                instrD <= 32'd0;
                validD <= 1'b0;
            end else begin
                instrD <= instrF;
                validD <= 1'b1;
            end
        end
    end

    // ID/EX: flush beats load; invalid decode slots enter E as an all-zero control bubble.
    always_ff @(posedge clk) begin
        if (!resetn || flushE) begin
            ctrlE    <= '0;
            rd1E     <= 32'd0;
            rd2E     <= 32'd0;
            signimmE <= 32'd0;
            rsE      <= 5'd0;
            rtE      <= 5'd0;
            rdE      <= 5'd0;
            pcplus4E <= 32'd0;
            validE   <= 1'b0;
        end else begin
            ctrlE    <= validD ? ctrlD : '0;
            rd1E     <= rd1D;
            rd2E     <= rd2D;
            signimmE <= signimmD;
            rsE      <= rsD;
            rtE      <= rtD;
            rdE      <= rdD;
            pcplus4E <= pcplus4D;
            validE   <= validD;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallD && !stallSat) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flushE && validD && !flushSat) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            proto_err <= 1'b0;
        end else if (protoViolation) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_fd_regs.sv
// Directed bench for pipe_fd_regs: each edge pushes a hand-computed expected
// state into a queue; a negedge monitor pops and compares.
module tb_pipe_fd_regs;

    localparam int unsigned CTRL_W = 12;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CTRL_W-1:0] CTRL_V = 12'h5A5;
    localparam logic [31:0]       RD1_V  = 32'h0000_0011;

    logic              clk = 1'b0;
    logic              resetn, stallF, stallD, flushE, pcsrcD, jumpD, cnt_clr;
    logic [31:0]       pcbranchD, pcjumpD, instrF;
    logic [31:0]       pcF, instrD, pcplus4D;
    logic              validD, validE, proto_err;
    logic [CTRL_W-1:0] ctrlD, ctrlE;
    logic [31:0]       rd1D, rd2D, signimmD, rd1E, rd2E, signimmE, pcplus4E;
    logic [4:0]        rsD, rtD, rdD, rsE, rtE, rdE;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    typedef struct {
        string       name;
        logic [31:0] pc, ins, p4d;
        logic        vd;
        logic [11:0] ce;
        logic        ve;
        logic [31:0] p4e;
        logic [3:0]  sc, fc;
        logic        pe;
        logic [31:0] r1e;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Instruction memory stand-in: word at address a is 0x20080001 + a/4.
    assign instrF = 32'h2008_0001 + (pcF >> 2);

    pipe_fd_regs #(.RESET_PC(32'h0), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .pcsrcD(pcsrcD), .jumpD(jumpD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
        .instrF(instrF), .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD),
        .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD),
        .rsD(rsD), .rtD(rtD), .rdD(rdD), .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E),
        .signimmE(signimmE), .rsE(rsE), .rtE(rtE), .rdE(rdE), .pcplus4E(pcplus4E),
        .validE(validE), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .proto_err(proto_err)
    );

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    // Monitor: one expectation per edge, compared half a cycle later.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk(e.name, "pcF",       pcF,                    e.pc);
            chk(e.name, "instrD",    instrD,                 e.ins);
            chk(e.name, "pcplus4D",  pcplus4D,               e.p4d);
            chk(e.name, "validD",    32'(validD),            32'(e.vd));
            chk(e.name, "ctrlE",     32'(ctrlE),             32'(e.ce));
            chk(e.name, "validE",    32'(validE),            32'(e.ve));
            chk(e.name, "pcplus4E",  pcplus4E,               e.p4e);
            chk(e.name, "stall_cnt", 32'(stall_cnt),         32'(e.sc));
            chk(e.name, "flush_cnt", 32'(flush_cnt),         32'(e.fc));
            chk(e.name, "proto_err", 32'(proto_err),         32'(e.pe));
            chk(e.name, "rd1E",      rd1E,                   e.r1e);
        end
    end

    task automatic tick(input string n, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] p4d, input logic vd, input logic [11:0] ce,
                        input logic ve, input logic [31:0] p4e, input logic [3:0] sc,
                        input logic [3:0] fc, input logic pe, input logic [31:0] r1e);
        exp_t e;
        @(posedge clk);
        e.name = n; e.pc = pc; e.ins = ins; e.p4d = p4d; e.vd = vd; e.ce = ce; e.ve = ve;
        e.p4e = p4e; e.sc = sc; e.fc = fc; e.pe = pe; e.r1e = r1e;
        expQ.push_back(e);
        #1;
    endtask

    function automatic logic [31:0] im(input logic [31:0] n);
        return 32'h2008_0000 + n;
    endfunction

    task automatic setStall(input logic f, input logic d, input logic e);
        stallF = f; stallD = d; flushE = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; setStall(0, 0, 0); pcsrcD = 0; jumpD = 0; cnt_clr = 0;
        pcbranchD = 32'h80; pcjumpD = 32'h40;
        ctrlD = CTRL_V; rd1D = RD1_V; rd2D = 32'h22; signimmD = 32'h33;
        rsD = 5'd1; rtD = 5'd2; rdD = 5'd3;
        #2;
        tick("rst0a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("rst0b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        resetn = 1'b1;
        tick("free1", 32'h4,  im(1), 32'h4,  1, 0,      0, 32'h0, 0, 0, 0, RD1_V);
        tick("free2", 32'h8,  im(2), 32'h8,  1, CTRL_V, 1, 32'h4, 0, 0, 0, RD1_V);
        tick("free3", 32'hC,  im(3), 32'hC,  1, CTRL_V, 1, 32'h8, 0, 0, 0, RD1_V);
        tick("free4", 32'h10, im(4), 32'h10, 1, CTRL_V, 1, 32'hC, 0, 0, 0, RD1_V);

        resetn = 1'b0;
        tick("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        tick("b1", 32'h4, im(1), 32'h4, 1, 0,      0, 32'h0, 0, 0, 0, RD1_V);
        tick("b2", 32'h8, im(2), 32'h8, 1, CTRL_V, 1, 32'h4, 0, 0, 0, RD1_V);

        setStall(1, 1, 1);
        tick("stall1", 32'h8, im(2), 32'h8, 1, 0, 0, 32'h0, 1, 1, 0, 0);
        tick("stall2", 32'h8, im(2), 32'h8, 1, 0, 0, 32'h0, 2, 2, 0, 0);
        setStall(0, 0, 0);
        tick("unstall", 32'hC, im(3), 32'hC, 1, CTRL_V, 1, 32'h8, 2, 2, 0, RD1_V);

        jumpD = 1;
        tick("jump", 32'h40, 0, 32'h10, 0, CTRL_V, 1, 32'hC, 2, 2, 0, RD1_V);
        jumpD = 0;
        tick("jtgt", 32'h44, im(32'h11), 32'h44, 1, 0, 0, 32'h10, 2, 2, 0, RD1_V);
        jumpD = 1; pcsrcD = 1;
        tick("jmpwins", 32'h40, 0, 32'h48, 0, CTRL_V, 1, 32'h44, 2, 2, 0, RD1_V);
        jumpD = 0; pcsrcD = 0;
        tick("jtgt2", 32'h44, im(32'h11), 32'h44, 1, 0, 0, 32'h48, 2, 2, 0, RD1_V);
        pcsrcD = 1;
        tick("branch", 32'h80, 0, 32'h48, 0, CTRL_V, 1, 32'h44, 2, 2, 0, RD1_V);
        tick("brInvalidD", 32'h84, im(32'h21), 32'h84, 1, 0, 0, 32'h48, 2, 2, 0, RD1_V);
        pcsrcD = 0;

        setStall(1, 1, 1);
        for (int i = 1; i <= 20; i++) begin
            logic [3:0] c;
            c = (2 + i > 15) ? 4'd15 : 4'(2 + i);
            tick("satHold", 32'h84, im(32'h21), 32'h84, 1, 0, 0, 32'h0, c, c, 0, 0);
        end
        cnt_clr = 1;
        tick("clrWins", 32'h84, im(32'h21), 32'h84, 1, 0, 0, 32'h0, 0, 0, 0, 0);
        cnt_clr = 0;
        tick("afterClr", 32'h84, im(32'h21), 32'h84, 1, 0, 0, 32'h0, 1, 1, 0, 0);
        setStall(0, 0, 0);
        tick("resume", 32'h88, im(32'h22), 32'h88, 1, CTRL_V, 1, 32'h84, 1, 1, 0, RD1_V);

        setStall(1, 1, 0);
        tick("dupToE", 32'h88, im(32'h22), 32'h88, 1, CTRL_V, 1, 32'h88, 2, 1, 1, RD1_V);
        setStall(0, 0, 0);
        tick("sticky", 32'h8C, im(32'h23), 32'h8C, 1, CTRL_V, 1, 32'h88, 2, 1, 1, RD1_V);

        setStall(1, 1, 0); resetn = 0;
        tick("rstInStall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setStall(0, 0, 0); resetn = 1;
        tick("g0", 32'h4, im(1), 32'h4, 1, 0, 0, 32'h0, 0, 0, 0, RD1_V);
        setStall(1, 0, 0);
        tick("fdMismatch", 32'h4, im(2), 32'h8, 1, CTRL_V, 1, 32'h4, 0, 0, 1, RD1_V);
        setStall(0, 0, 0); jumpD = 1; pcjumpD = 32'hFFFF_FFFC;
        tick("jmpTop", 32'hFFFF_FFFC, 0, 32'h8, 0, CTRL_V, 1, 32'h8, 0, 0, 1, RD1_V);
        jumpD = 0;
        tick("pcWrap", 32'h0, 32'h6008_0000, 32'h0, 1, 0, 0, 32'h8, 0, 0, 1, RD1_V);

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
